// File: rtl/t02_mem_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds FSM state, owner encoding and the abort fill word.
package t02_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/t02_arb_pick.sv
// Winner select between fetch and data requesters.
// Data normally wins; a waiting fetch wins once starved.
module t02_arb_pick
    import t02_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   grant_en,
    input  logic   i_req,
    input  logic   d_req,
    output logic   grant,
    output owner_t owner
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          fetch_wins;

    // Pick the winner and work out the next starvation count.
    always_comb begin
        fetch_wins = i_req && (!d_req || (starve_q == SMAX));
        grant      = grant_en && (i_req || d_req);
        owner      = fetch_wins ? OWN_I : OWN_D;
        starve_d   = starve_q;
        if (grant) begin
            if (!fetch_wins && i_req) begin
                if (starve_q != SMAX) begin
                    starve_d = starve_q + 1'b1;
                end
            end else begin
                starve_d = '0;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/t02_mem_arbiter.sv
// Shares one RAM/bus port between fetch and load/store.
// One transaction at a time: IDLE, ISSUE, WAIT, RESP.
module t02_mem_arbiter
    import t02_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [DATA_W-1:0] FILL = DATA_W'(TIMEOUT_DATA);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              wr_q, wr_d;
    logic              abort_q, abort_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;

    logic   d_req;
    logic   grant_en;
    logic   grant;
    owner_t pick;
    logic   on_bus;

    assign d_req    = d_ren | d_wen;
    assign grant_en = (state_q == IDLE) && !halt;

    t02_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .CLK     (CLK),
        .RST     (RST),
        .grant_en(grant_en),
        .i_req   (i_req),
        .d_req   (d_req),
        .grant   (grant),
        .owner   (pick)
    );

    // Transaction sequencing, request latching and read capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        abort_d  = abort_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = pick;
                    abort_d = 1'b0;
                    tmo_d   = '0;
                    if (pick == OWN_I) begin
                        addr_d = i_addr;
                        wr_d   = 1'b0;
                    end else begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        wr_d    = d_wen;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!ram_busy) begin
                    if (!wr_q) begin
                        if (owner_q == OWN_I) begin
                            irdata_d = ram_rdata;
                        end else begin
                            drdata_d = ram_rdata;
                        end
                    end
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_MAX) begin
                        abort_d = 1'b1;
                        if (!wr_q) begin
                            if (owner_q == OWN_I) begin
                                irdata_d = FILL;
                            end else begin
                                drdata_d = FILL;
                            end
                        end
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                tmo_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            wr_q     <= 1'b0;
            abort_q  <= 1'b0;
            tmo_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            abort_q  <= abort_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    // Strobes and ready pulses decode straight from registered state.
    always_comb begin
        on_bus  = (state_q == ISSUE) || (state_q == WAIT);
        ram_ren = on_bus && !wr_q;
        ram_wen = on_bus && wr_q;
        i_ready = (state_q == RESP) && (owner_q == OWN_I);
        d_ready = (state_q == RESP) && (owner_q == OWN_D);
        err     = (state_q == RESP) && abort_q;
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign i_rdata   = irdata_q;
    assign d_rdata   = drdata_q;

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Directed bench for t02_mem_arbiter.
// Inputs change 1ns after the rising edge; outputs sampled there.
module tb_t02_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        halt;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        err;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_busy;

    int vec  = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    t02_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4),
        .TIMEOUT(255)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .halt     (halt),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_ren    (d_ren),
        .d_wen    (d_wen),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .err      (err),
        .ram_ren  (ram_ren),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_busy (ram_busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; halt = 1'b0;
        i_req = 1'b1; i_addr = 32'h44;
        d_ren = 1'b1; d_wen = 1'b0;
        d_addr = 32'h88; d_wdata = 32'h99;
        ram_busy = 1'b0; ram_rdata = 32'h5555AAAA;
        tick(); tick(); tick();
        vec++;
        if ({ram_ren, ram_wen, i_ready, d_ready, err} !== 5'b0) begin
            errs++;
            $display("FAIL reset_strobes got %b want 00000",
                     {ram_ren, ram_wen, i_ready, d_ready, err});
        end
        vec++;
        if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
            errs++;
            $display("FAIL reset_bus got %h/%h want 0/0", ram_addr, ram_wdata);
        end
        vec++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errs++;
            $display("FAIL reset_rdata got %h/%h want 0/0", i_rdata, d_rdata);
        end
        RST = 1'b0; i_req = 1'b0; d_ren = 1'b0;
        tick();
        vec++;
        if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle got %b%b want 00", ram_ren, ram_wen);
        end
    endtask

    task automatic test_load();
        int ren_n; bit seen; bit bad_i; bit bad_a;
        logic [31:0] rd; logic er;
        ren_n = 0; seen = 0; bad_i = 0; bad_a = 0; rd = '0; er = 1'b0;
        d_addr = 32'h100; d_ren = 1'b1;
        ram_rdata = 32'hCAFEF00D; ram_busy = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (ram_ren) begin
                ren_n++;
                if (ram_addr !== 32'h100) bad_a = 1;
                d_addr = 32'h0BAD0000;
            end
            ram_busy = ram_ren && (ren_n <= 3);
            if (i_ready) bad_i = 1;
            if (d_ready) begin
                seen = 1; rd = d_rdata; er = err; d_ren = 1'b0;
            end
        end
        vec++;
        if (!seen) begin
            errs++; $display("FAIL load_ready got none want pulse");
        end
        vec++;
        if (ren_n != 4) begin
            errs++; $display("FAIL load_ren_cycles got %0d want 4", ren_n);
        end
        vec++;
        if (bad_a) begin
            errs++; $display("FAIL load_addr got changed want 00000100");
        end
        vec++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errs++;
            $display("FAIL load_data got %h err %b want cafef00d err 0", rd, er);
        end
        vec++;
        if (bad_i) begin
            errs++; $display("FAIL load_i_ready got 1 want 0");
        end
        tick();
        vec++;
        if (d_ready !== 1'b0 || d_rdata !== 32'hCAFEF00D) begin
            errs++;
            $display("FAIL load_pulse got %b %h want 0 cafef00d", d_ready, d_rdata);
        end
    endtask

    task automatic test_store();
        int wen_n; int rdy_at; bit bad; bit bad_r;
        wen_n = 0; rdy_at = 0; bad = 0; bad_r = 0;
        d_wen = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
        ram_busy = 1'b0;
        for (int c = 1; c <= 10 && rdy_at == 0; c++) begin
            tick();
            if (ram_wen) begin
                wen_n++;
                if (ram_addr !== 32'h200 || ram_wdata !== 32'h12345678) bad = 1;
                d_wdata = 32'h0;
            end
            if (ram_ren) bad_r = 1;
            if (d_ready) begin
                rdy_at = c; d_wen = 1'b0;
            end
        end
        vec++;
        if (rdy_at != 3) begin
            errs++; $display("FAIL store_latency got %0d want 3", rdy_at);
        end
        vec++;
        if (wen_n != 2 || bad_r) begin
            errs++;
            $display("FAIL store_wen got %0d ren %b want 2 ren 0", wen_n, bad_r);
        end
        vec++;
        if (bad) begin
            errs++; $display("FAIL store_latch got wrong addr/data want 200/12345678");
        end
        vec++;
        if (d_rdata !== 32'hCAFEF00D) begin
            errs++; $display("FAIL store_rdata got %h want cafef00d", d_rdata);
        end
        tick();
    endtask

    task automatic test_both();
        int ren_n; int wen_n; bit seen;
        ren_n = 0; wen_n = 0; seen = 0;
        d_ren = 1'b1; d_wen = 1'b1;
        d_addr = 32'h240; d_wdata = 32'hA0A0A0A0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (ram_ren) ren_n++;
            if (ram_wen) wen_n++;
            if (d_ready) begin
                seen = 1; d_ren = 1'b0; d_wen = 1'b0;
            end
        end
        vec++;
        if (wen_n != 2 || ren_n != 0) begin
            errs++;
            $display("FAIL both_is_store got wen %0d ren %0d want 2 0", wen_n, ren_n);
        end
        tick();
    endtask

    task automatic test_starve();
        int n; logic [9:0] got; bit both; bit bad_rd;
        n = 0; got = '0; both = 0; bad_rd = 0;
        i_req = 1'b1; i_addr = 32'h0;
        d_ren = 1'b1; d_addr = 32'h300;
        ram_busy = 1'b0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            tick();
            ram_rdata = (ram_addr == 32'h0) ? 32'hA5A50000 : 32'h0000D00D;
            if (i_ready && d_ready) both = 1;
            if (i_ready) begin
                got[n] = 1'b1;
                if (i_rdata !== 32'hA5A50000) bad_rd = 1;
                n++;
            end else if (d_ready) begin
                if (d_rdata !== 32'h0000D00D) bad_rd = 1;
                n++;
            end
            if (n == 10) begin
                i_req = 1'b0; d_ren = 1'b0;
            end
        end
        vec++;
        if (n != 10) begin
            errs++; $display("FAIL starve_count got %0d want 10", n);
        end
        vec++;
        if (got !== 10'b1000010000) begin
            errs++;
            $display("FAIL starve_order got %b want 1000010000", got);
        end
        vec++;
        if (both) begin
            errs++; $display("FAIL starve_dual_ready got 1 want 0");
        end
        vec++;
        if (bad_rd) begin
            errs++; $display("FAIL starve_rdata got wrong word want a5a50000/0000d00d");
        end
        tick();
    endtask

    task automatic test_timeout();
        int ren_n; bit seen; bit stray; logic er; logic [31:0] rd;
        ren_n = 0; seen = 0; stray = 0; er = 1'b0; rd = '0;
        d_ren = 1'b1; d_addr = 32'h400; ram_busy = 1'b1;
        for (int c = 0; c < 400 && !seen; c++) begin
            tick();
            if (ram_ren) ren_n++;
            if (err && !d_ready) stray = 1;
            if (d_ready) begin
                seen = 1; er = err; rd = d_rdata; d_ren = 1'b0;
            end
        end
        vec++;
        if (!seen) begin
            errs++; $display("FAIL tmo_ready got none want pulse");
        end
        vec++;
        if (ren_n != 256) begin
            errs++; $display("FAIL tmo_ren_cycles got %0d want 256", ren_n);
        end
        vec++;
        if (er !== 1'b1 || stray) begin
            errs++; $display("FAIL tmo_err got %b stray %b want 1 0", er, stray);
        end
        vec++;
        if (rd !== 32'hDEADBEEF) begin
            errs++; $display("FAIL tmo_rdata got %h want deadbeef", rd);
        end
        ram_busy = 1'b0;
        tick();
        vec++;
        if (err !== 1'b0 || d_ready !== 1'b0) begin
            errs++; $display("FAIL tmo_pulse got %b%b want 00", err, d_ready);
        end
    endtask

    task automatic test_halt();
        int ren_n; bit seen; logic [31:0] rd; int strobes; bit dseen;
        ren_n = 0; seen = 0; rd = '0; strobes = 0; dseen = 0;
        i_req = 1'b1; i_addr = 32'h40;
        ram_rdata = 32'h11112222; ram_busy = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (ram_ren) ren_n++;
            ram_busy = ram_ren && (ren_n <= 2);
            if (ren_n == 2) begin
                halt = 1'b1; d_ren = 1'b1; d_addr = 32'h500;
            end
            if (i_ready) begin
                seen = 1; rd = i_rdata; i_req = 1'b0;
            end
        end
        vec++;
        if (!seen || rd !== 32'h11112222) begin
            errs++;
            $display("FAIL halt_fetch got %b %h want 1 11112222", seen, rd);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ram_ren || ram_wen || d_ready) strobes++;
        end
        vec++;
        if (strobes != 0) begin
            errs++; $display("FAIL halt_block got %0d want 0", strobes);
        end
        halt = 1'b0;
        ram_rdata = 32'h33334444;
        tick();
        vec++;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h500) begin
            errs++;
            $display("FAIL halt_release got %b %h want 1 00000500", ram_ren, ram_addr);
        end
        for (int c = 0; c < 10 && !dseen; c++) begin
            tick();
            if (d_ready) begin
                dseen = 1; d_ren = 1'b0;
            end
        end
        vec++;
        if (!dseen || d_rdata !== 32'h33334444) begin
            errs++;
            $display("FAIL halt_load got %b %h want 1 33334444", dseen, d_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        d_ren = 1'b1; d_addr = 32'h600;
        ram_busy = 1'b1; ram_rdata = 32'h77778888;
        tick(); tick();
        RST = 1'b1;
        tick();
        vec++;
        if (ram_ren !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_strobes got %b%b%b want 000",
                     ram_ren, i_ready, d_ready);
        end
        vec++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || ram_addr !== 32'h0) begin
            errs++;
            $display("FAIL rstmid_regs got %h %h %h want 0 0 0",
                     i_rdata, d_rdata, ram_addr);
        end
        RST = 1'b0; ram_busy = 1'b0;
        tick();
        vec++;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h600) begin
            errs++;
            $display("FAIL rstmid_issue got %b %h want 1 00000600", ram_ren, ram_addr);
        end
        tick(); tick();
        vec++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h77778888) begin
            errs++;
            $display("FAIL rstmid_load got %b %h want 1 77778888", d_ready, d_rdata);
        end
        d_ren = 1'b0;
        tick();
        vec++;
        if (d_ready !== 1'b0 || ram_ren !== 1'b0) begin
            errs++; $display("FAIL rstmid_idle got %b%b want 00", d_ready, ram_ren);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_both();
        test_starve();
        test_timeout();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
